// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
// Shared definitions for the ALU microsequencer: opcode encodings, the
// sequencer FSM state type, instruction field positions and small field
// extraction helpers.
//
// Instruction layout (16 bits):
//   [15:13] opcode   [12] L   [11:10] ALUop   [9:8] rd
//   [7:6]   ra       [5:4] rb [3:0]   imm     [AW-1:0] jump target
package alu_seq_pkg;

    localparam logic [2:0] OP_OUT  = 3'b000;
    localparam logic [2:0] OP_ALU  = 3'b001;
    localparam logic [2:0] OP_LDI  = 3'b010;
    localparam logic [2:0] OP_JMP  = 3'b011;
    localparam logic [2:0] OP_JZ   = 3'b100;
    localparam logic [2:0] OP_JC   = 3'b101;
    localparam logic [2:0] OP_JS   = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALTED
    } state_t;

    localparam int F_OP_LO    = 13;
    localparam int F_L        = 12;
    localparam int F_ALUOP_LO = 10;
    localparam int F_RD_LO    = 8;
    localparam int F_RA_LO    = 6;
    localparam int F_RB_LO    = 4;
    localparam int F_IMM_LO   = 0;

    function automatic logic [2:0] get_opcode(input logic [15:0] ir);
        return ir[F_OP_LO +: 3];
    endfunction

    function automatic logic [1:0] get_reg(input logic [15:0] ir, input int lo);
        return ir[lo +: 2];
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if
// Bus bundle between the sequencer, its program memory and the external ALU.
//   iaddr/idata            : synchronous program memory port
//   A/B/ALUop/L            : ALU operands and operation select
//   R/zero/carry/sign      : ALU result and flags (combinational)
// master = sequencer side, slave = memory/ALU side.
interface alu_seq_if #(
    parameter int AW = 8
);
    logic [AW-1:0] iaddr;
    logic [15:0]   idata;
    logic [3:0]    A;
    logic [3:0]    B;
    logic [1:0]    ALUop;
    logic          L;
    logic [3:0]    R;
    logic          zero;
    logic          carry;
    logic          sign;

    modport master (
        output iaddr, A, B, ALUop, L,
        input  idata, R, zero, carry, sign
    );

    modport slave (
        input  iaddr, A, B, ALUop, L,
        output idata, R, zero, carry, sign
    );
endinterface

// File: rtl/alu_seq_rf4x4.sv
// rf4x4
// 4-entry x 4-bit register file with two combinational read ports and one
// synchronous write port. Asynchronous active-low reset clears all entries.
//   clk, rst_n        : clock, async active-low reset
//   ra_addr/ra_data   : read port A
//   rb_addr/rb_data   : read port B
//   we/wa/wd          : write enable, address, data
module rf4x4 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] ra_addr,
    output logic [3:0] ra_data,
    input  logic [1:0] rb_addr,
    output logic [3:0] rb_data,
    input  logic       we,
    input  logic [1:0] wa,
    input  logic [3:0] wd
);
    logic [3:0] word [4];

    // Reads are combinational, so a write addressed to a register being read
    // in the same cycle returns the old value; the new one lands at the edge.
    for (genvar gi = 0; gi < 4; gi++) begin : g_entry
        logic [3:0] q_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q_reg <= 4'h0;
            end else if (we && (wa == 2'(gi))) begin
                q_reg <= wd;
            end
        end

        assign word[gi] = q_reg;
    end

    assign ra_data = word[ra_addr];
    assign rb_data = word[rb_addr];

endmodule

// File: rtl/alu_seq.sv
// alu_seq
// Microsequencer driving an external 4-bit ALU. Each instruction takes three
// cycles: FETCH (iaddr=PC), DECODE (idata returns, IR loaded at the edge) and
// EXEC (operands decoded from IR, results committed at the edge).
//   clk       : clock
//   reset     : asynchronous active-low reset
//   start     : launch from IDLE, or restart from PC 0 when HALTED
//   bus       : program memory + ALU bundle (master side)
//   out       : value written by OUT
//   out_valid : one-cycle pulse after OUT commits
//   halted    : high while HALTED
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     start,
    alu_seq_if.master bus,
    output logic [3:0] out,
    output logic     out_valid,
    output logic     halted
);
    state_t        state_reg, state_next;
    logic [AW-1:0] pc_reg, pc_next;
    logic [15:0]   ir_reg;
    logic          z_reg, c_reg, s_reg;
    logic [3:0]    out_reg;
    logic          out_valid_reg;

    logic          ir_load;
    logic          rf_we;
    logic          flags_we;
    logic          out_load;
    logic [3:0]    rf_wd;
    logic [3:0]    ra_data, rb_data;
    logic          in_exec;

    logic [2:0]    opcode;
    logic [1:0]    rd, ra, rb;
    logic [AW-1:0] target;

    assign opcode  = get_opcode(ir_reg);
    assign rd      = get_reg(ir_reg, F_RD_LO);
    assign ra      = get_reg(ir_reg, F_RA_LO);
    assign rb      = get_reg(ir_reg, F_RB_LO);
    assign target  = ir_reg[AW-1:0];
    assign in_exec = (state_reg == S_EXEC);

    rf4x4 u_rf (
        .clk     (clk),
        .rst_n   (reset),
        .ra_addr (ra),
        .ra_data (ra_data),
        .rb_addr (rb),
        .rb_data (rb_data),
        .we      (rf_we),
        .wa      (rd),
        .wd      (rf_wd)
    );

    // ALU sees operands only during EXEC; elsewhere the lines idle at 0.
    assign bus.A     = in_exec ? ra_data : 4'h0;
    assign bus.B     = in_exec ? rb_data : 4'h0;
    assign bus.ALUop = in_exec ? ir_reg[F_ALUOP_LO +: 2] : 2'b00;
    assign bus.L     = in_exec ? ir_reg[F_L] : 1'b0;
    assign bus.iaddr = pc_reg;

    assign rf_wd     = (opcode == OP_ALU) ? bus.R : ir_reg[F_IMM_LO +: 4];

    assign out       = out_reg;
    assign out_valid = out_valid_reg;
    assign halted    = (state_reg == S_HALTED);

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        ir_load    = 1'b0;
        rf_we      = 1'b0;
        flags_we   = 1'b0;
        out_load   = 1'b0;
        unique case (state_reg)
            S_IDLE: begin
                if (start) state_next = S_FETCH;
            end
            S_FETCH: begin
                state_next = S_DECODE;
            end
            S_DECODE: begin
                ir_load    = 1'b1;
                state_next = S_EXEC;
            end
            S_EXEC: begin
                state_next = S_FETCH;
                pc_next    = pc_reg + 1'b1;
                unique case (opcode)
                    OP_OUT:  out_load = 1'b1;
                    OP_ALU:  begin
                        rf_we    = 1'b1;
                        flags_we = 1'b1;
                    end
                    OP_LDI:  rf_we = 1'b1;
                    OP_JMP:  pc_next = target;
                    OP_JZ:   if (z_reg) pc_next = target;
                    OP_JC:   if (c_reg) pc_next = target;
                    OP_JS:   if (s_reg) pc_next = target;
                    OP_HALT: begin
                        pc_next    = pc_reg;
                        state_next = S_HALTED;
                    end
                    default: ;
                endcase
            end
            S_HALTED: begin
                if (start) begin
                    pc_next    = '0;
                    state_next = S_FETCH;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= S_IDLE;
            pc_reg        <= '0;
            ir_reg        <= 16'h0000;
            z_reg         <= 1'b0;
            c_reg         <= 1'b0;
            s_reg         <= 1'b0;
            out_reg       <= 4'h0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            out_valid_reg <= out_load;
            if (ir_load) ir_reg <= bus.idata;
            if (flags_we) begin
                z_reg <= bus.zero;
                c_reg <= bus.carry;
                s_reg <= bus.sign;
            end
            if (out_load) out_reg <= rb_data;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
    localparam int AW = 8;
    localparam logic [15:0] HALT = 16'hE000;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [3:0] out;
    logic       out_valid;
    logic       halted;

    int checks = 0;
    int errors = 0;
    int pulse_err = 0;
    logic ov_prev = 1'b0;
    logic [3:0] out_q[$];

    alu_seq_if #(.AW(AW)) bus();

    alu_seq #(.AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bus       (bus),
        .out       (out),
        .out_valid (out_valid),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    // Synchronous program memory
    logic [15:0] mem [256];
    always @(posedge clk) bus.idata <= mem[bus.iaddr];

    // External 4-bit ALU: L=0 arithmetic (add, sub, inc, dec), L=1 logic
    // (and, or, xor, not A). Returns {sign, carry, zero, R}.
    function automatic logic [6:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                             input logic [1:0] op, input logic l);
        logic [4:0] t;
        t = 5'd0;
        if (!l) begin
            case (op)
                2'b00: t = {1'b0, a} + {1'b0, b};
                2'b01: t = {1'b0, a} + {1'b0, ~b} + 5'd1;
                2'b10: t = {1'b0, a} + 5'd1;
                default: t = {1'b0, a} + 5'h0F;
            endcase
        end else begin
            case (op)
                2'b00: t = {1'b0, a & b};
                2'b01: t = {1'b0, a | b};
                2'b10: t = {1'b0, a ^ b};
                default: t = {1'b0, ~a};
            endcase
        end
        return {t[3], t[4], (t[3:0] == 4'h0), t[3:0]};
    endfunction

    assign {bus.sign, bus.carry, bus.zero, bus.R} = alu_model(bus.A, bus.B, bus.ALUop, bus.L);

    // Output monitor
    always @(negedge clk) begin
        if (out_valid) out_q.push_back(out);
        if (out_valid && ov_prev) pulse_err++;
        ov_prev = out_valid;
    end

    // Instruction encoders
    function automatic logic [15:0] i_out(input logic [1:0] rb);
        return {3'b000, 1'b0, 2'b00, 2'b00, 2'b00, rb, 4'h0};
    endfunction
    function automatic logic [15:0] i_alu(input logic l, input logic [1:0] op, input logic [1:0] rd,
                                          input logic [1:0] ra, input logic [1:0] rb);
        return {3'b001, l, op, rd, ra, rb, 4'h0};
    endfunction
    function automatic logic [15:0] i_ldi(input logic [1:0] rd, input logic [3:0] imm);
        return {3'b010, 1'b0, 2'b00, rd, 2'b00, 2'b00, imm};
    endfunction
    function automatic logic [15:0] i_jmp(input logic [2:0] opc, input logic [7:0] tgt);
        return {opc, 5'b00000, tgt};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = HALT;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        out_q.delete();
        pulse_err = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_halt(input string name);
        int n;
        n = 0;
        while (!halted && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (halted !== 1'b1) begin
            errors++;
            $display("FAIL %s_halt: halted=%b required 1", name, halted);
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp[$];
        clear_mem();
        mem[0] = i_ldi(2'd0, 4'h5);
        mem[1] = i_ldi(2'd1, 4'h3);
        mem[2] = i_alu(1'b0, 2'b00, 2'd2, 2'd0, 2'd1);
        do_reset();
        checks++;
        if (bus.iaddr !== 8'h00 || halted !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: iaddr=%h halted=%b out_valid=%b required 00 0 0",
                     bus.iaddr, halted, out_valid);
        end
        pulse_start();
        repeat (8) tick();
        checks++;
        if (bus.A !== 4'h5 || bus.B !== 4'h3) begin
            errors++;
            $display("FAIL exec_operands: A=%h B=%h required 5 3", bus.A, bus.B);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (bus.iaddr !== 8'h00) begin
            errors++;
            $display("FAIL reset_iaddr: iaddr=%h required 00", bus.iaddr);
        end
        checks++;
        if (bus.A !== 4'h0 || bus.B !== 4'h0 || bus.ALUop !== 2'b00 || bus.L !== 1'b0) begin
            errors++;
            $display("FAIL reset_alu_lines: A=%h B=%h ALUop=%b L=%b required 0 0 00 0",
                     bus.A, bus.B, bus.ALUop, bus.L);
        end
        checks++;
        if (out !== 4'h0 || out_valid !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_outs: out=%h out_valid=%b halted=%b required 0 0 0",
                     out, out_valid, halted);
        end
        tick();
        reset = 1'b1;
        tick();
        // Regs and flags must still be zero: OUT all, all conditional jumps untaken
        clear_mem();
        mem[0]    = i_out(2'd0);
        mem[1]    = i_out(2'd1);
        mem[2]    = i_out(2'd2);
        mem[3]    = i_jmp(3'b100, 8'h40);
        mem[4]    = i_jmp(3'b101, 8'h40);
        mem[5]    = i_jmp(3'b110, 8'h40);
        mem[6]    = i_ldi(2'd3, 4'h6);
        mem[7]    = i_out(2'd3);
        mem[8'h40] = i_ldi(2'd3, 4'h9);
        mem[8'h41] = i_out(2'd3);
        out_q.delete();
        pulse_start();
        wait_halt("reset");
        exp = '{4'h0, 4'h0, 4'h0, 4'h6};
        checks++;
        if (out_q.size() != exp.size()) begin
            errors++;
            $display("FAIL reset_after_outs: count=%0d required %0d", out_q.size(), exp.size());
        end else begin
            for (int k = 0; k < exp.size(); k++) begin
                checks++;
                if (out_q[k] !== exp[k]) begin
                    errors++;
                    $display("FAIL reset_after_out%0d: out=%h required %h", k, out_q[k], exp[k]);
                end
            end
        end
    endtask

    task automatic test_add();
        logic [3:0] exp[$];
        clear_mem();
        mem[0]     = i_ldi(2'd0, 4'h5);
        mem[1]     = i_ldi(2'd1, 4'h3);
        mem[2]     = i_alu(1'b0, 2'b00, 2'd2, 2'd0, 2'd1);
        mem[3]     = i_out(2'd2);
        mem[4]     = i_jmp(3'b100, 8'h40);
        mem[5]     = i_ldi(2'd3, 4'h6);
        mem[6]     = i_out(2'd3);
        mem[8'h40] = i_ldi(2'd3, 4'h9);
        mem[8'h41] = i_out(2'd3);
        do_reset();
        pulse_start();
        wait_halt("add");
        exp = '{4'h8, 4'h6};
        checks++;
        if (out_q.size() != exp.size()) begin
            errors++;
            $display("FAIL add_outs: count=%0d required %0d", out_q.size(), exp.size());
        end else begin
            for (int k = 0; k < exp.size(); k++) begin
                checks++;
                if (out_q[k] !== exp[k]) begin
                    errors++;
                    $display("FAIL add_out%0d: out=%h required %h", k, out_q[k], exp[k]);
                end
            end
        end
        checks++;
        if (pulse_err != 0) begin
            errors++;
            $display("FAIL add_pulse: long out_valid pulses=%0d required 0", pulse_err);
        end
        checks++;
        if (bus.iaddr !== 8'h07 || out !== 4'h6) begin
            errors++;
            $display("FAIL add_halt_pc: iaddr=%h out=%h required 07 6", bus.iaddr, out);
        end
    endtask

    task automatic test_carry();
        logic [3:0] exp[$];
        for (int v = 0; v < 2; v++) begin
            clear_mem();
            mem[0]     = i_ldi(2'd0, 4'hF);
            mem[1]     = i_ldi(2'd1, (v == 0) ? 4'h1 : 4'h0);
            mem[2]     = i_alu(1'b0, 2'b00, 2'd2, 2'd0, 2'd1);
            mem[3]     = i_out(2'd2);
            mem[4]     = i_jmp(3'b101, 8'h20);
            mem[5]     = i_ldi(2'd3, 4'h5);
            mem[6]     = i_out(2'd3);
            mem[8'h20] = i_ldi(2'd3, 4'hA);
            mem[8'h21] = i_out(2'd3);
            do_reset();
            pulse_start();
            wait_halt("carry");
            if (v == 0) exp = '{4'h0, 4'hA};
            else        exp = '{4'hF, 4'h5};
            checks++;
            if (out_q.size() != exp.size()) begin
                errors++;
                $display("FAIL carry%0d_outs: count=%0d required %0d", v, out_q.size(), exp.size());
            end else begin
                for (int k = 0; k < exp.size(); k++) begin
                    checks++;
                    if (out_q[k] !== exp[k]) begin
                        errors++;
                        $display("FAIL carry%0d_out%0d: out=%h required %h", v, k, out_q[k], exp[k]);
                    end
                end
            end
            checks++;
            if (bus.iaddr !== ((v == 0) ? 8'h22 : 8'h07)) begin
                errors++;
                $display("FAIL carry%0d_halt_pc: iaddr=%h required %h", v, bus.iaddr,
                         (v == 0) ? 8'h22 : 8'h07);
            end
        end
    endtask

    task automatic test_zero_keep();
        logic [3:0] exp[$];
        clear_mem();
        mem[0]     = i_ldi(2'd0, 4'h3);
        mem[1]     = i_ldi(2'd1, 4'h3);
        mem[2]     = i_alu(1'b0, 2'b01, 2'd2, 2'd0, 2'd1);
        mem[3]     = i_jmp(3'b100, 8'h10);
        mem[4]     = i_ldi(2'd3, 4'h1);
        mem[5]     = i_out(2'd3);
        mem[8'h10] = i_ldi(2'd3, 4'h7);
        mem[8'h11] = i_jmp(3'b100, 8'h18);
        mem[8'h12] = i_ldi(2'd3, 4'h2);
        mem[8'h13] = i_out(2'd3);
        mem[8'h18] = i_out(2'd3);
        do_reset();
        pulse_start();
        wait_halt("zero");
        exp = '{4'h7};
        checks++;
        if (out_q.size() != exp.size()) begin
            errors++;
            $display("FAIL zero_outs: count=%0d required %0d", out_q.size(), exp.size());
        end else begin
            checks++;
            if (out_q[0] !== exp[0]) begin
                errors++;
                $display("FAIL zero_out0: out=%h required %h", out_q[0], exp[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp[$];
        clear_mem();
        mem[0]     = i_ldi(2'd0, 4'h2);
        mem[1]     = i_ldi(2'd1, 4'h3);
        mem[2]     = i_alu(1'b0, 2'b00, 2'd0, 2'd0, 2'd1);
        mem[3]     = i_alu(1'b0, 2'b00, 2'd0, 2'd0, 2'd0);
        mem[4]     = i_alu(1'b1, 2'b10, 2'd2, 2'd0, 2'd1);
        mem[5]     = i_out(2'd0);
        mem[6]     = i_out(2'd2);
        mem[7]     = i_jmp(3'b110, 8'h30);
        mem[8'h30] = i_ldi(2'd3, 4'hC);
        mem[8'h31] = i_out(2'd3);
        do_reset();
        pulse_start();
        wait_halt("b2b");
        exp = '{4'hA, 4'h9, 4'hC};
        checks++;
        if (out_q.size() != exp.size()) begin
            errors++;
            $display("FAIL b2b_outs: count=%0d required %0d", out_q.size(), exp.size());
        end else begin
            for (int k = 0; k < exp.size(); k++) begin
                checks++;
                if (out_q[k] !== exp[k]) begin
                    errors++;
                    $display("FAIL b2b_out%0d: out=%h required %h", k, out_q[k], exp[k]);
                end
            end
        end
    endtask

    task automatic test_wrap();
        clear_mem();
        mem[0]     = i_jmp(3'b011, 8'hFF);
        mem[8'hFF] = i_ldi(2'd0, 4'h7);
        do_reset();
        pulse_start();
        checks++;
        if (bus.iaddr !== 8'h00) begin
            errors++;
            $display("FAIL wrap_first_fetch: iaddr=%h required 00", bus.iaddr);
        end
        repeat (3) tick();
        checks++;
        if (bus.iaddr !== 8'hFF) begin
            errors++;
            $display("FAIL wrap_jmp: iaddr=%h required ff", bus.iaddr);
        end
        repeat (3) tick();
        checks++;
        if (bus.iaddr !== 8'h00) begin
            errors++;
            $display("FAIL wrap_pc: iaddr=%h required 00", bus.iaddr);
        end
    endtask

    task automatic test_restart();
        logic [3:0] exp[$];
        clear_mem();
        mem[0] = i_ldi(2'd1, 4'hB);
        mem[1] = i_ldi(2'd2, 4'h4);
        do_reset();
        pulse_start();
        wait_halt("restart_first");
        checks++;
        if (bus.iaddr !== 8'h02) begin
            errors++;
            $display("FAIL restart_halt_pc: iaddr=%h required 02", bus.iaddr);
        end
        mem[0] = i_out(2'd1);
        mem[1] = i_out(2'd2);
        out_q.delete();
        pulse_start();
        checks++;
        if (halted !== 1'b0 || bus.iaddr !== 8'h00) begin
            errors++;
            $display("FAIL restart_fetch: halted=%b iaddr=%h required 0 00", halted, bus.iaddr);
        end
        wait_halt("restart_second");
        exp = '{4'hB, 4'h4};
        checks++;
        if (out_q.size() != exp.size()) begin
            errors++;
            $display("FAIL restart_outs: count=%0d required %0d", out_q.size(), exp.size());
        end else begin
            for (int k = 0; k < exp.size(); k++) begin
                checks++;
                if (out_q[k] !== exp[k]) begin
                    errors++;
                    $display("FAIL restart_out%0d: out=%h required %h", k, out_q[k], exp[k]);
                end
            end
        end
    endtask

    initial begin
        clear_mem();
        test_reset();
        $display("test_reset done checks=%0d errors=%0d", checks, errors);
        test_add();
        $display("test_add done checks=%0d errors=%0d", checks, errors);
        test_carry();
        $display("test_carry done checks=%0d errors=%0d", checks, errors);
        test_zero_keep();
        $display("test_zero_keep done checks=%0d errors=%0d", checks, errors);
        test_back_to_back();
        $display("test_back_to_back done checks=%0d errors=%0d", checks, errors);
        test_wrap();
        $display("test_wrap done checks=%0d errors=%0d", checks, errors);
        test_restart();
        $display("test_restart done checks=%0d errors=%0d", checks, errors);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Microsequencer that drives the 4-bit ALU from the initiator side. It fetches 16-bit instructions from an external synchronous program memory. It presents operands and `ALUop`/`L` to the ALU and captures `R` and the `zero`/`carry`/`sign` flags into a 4×4-bit register file and flag register. It executes conditional jumps on the latched flags. It sits between program memory and the ALU and makes the ALU a runnable datapath.

## Interface
- `AW`, default 8: program address width; PC wraps modulo 2^AW.
- `clk` input, 1 bit: the single clock; all state changes on the rising edge.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `start` input, 1 bit: begins execution from IDLE or HALTED.
- `iaddr` output, AW bits: program memory address; registered and equal to PC.
- `idata` input, 16 bits: instruction word, valid one cycle after `iaddr` is presented.
- `A` output, 4 bits: ALU operand A.
- `B` output, 4 bits: ALU operand B.
- `ALUop` output, 2 bits: ALU operation select.
- `L` output, 1 bit: ALU logic/arithmetic select.
- `R` input, 4 bits: ALU result, combinational from `A`, `B`, `ALUop`, `L`.
- `zero` input, 1 bit: ALU zero flag.
- `carry` input, 1 bit: ALU carry flag.
- `sign` input, 1 bit: ALU sign flag.
- `out` output, 4 bits: value written by OUT.
- `out_valid` output, 1 bit: one-cycle pulse when `out` is updated.
- `halted` output, 1 bit: high while in the HALTED state.

## Operation
- Opcode is `idata[15:13]`.
- 000 OUT: `out` ← reg[`[5:4]`]; `out_valid` is 1 for that cycle.
- 001 ALU: `L`=`[12]`, `ALUop`=`[11:10]`, `A`=reg[`[7:6]`], `B`=reg[`[5:4]`]; reg[`[9:8]`] ← `R`; Z/C/S ← `zero`/`carry`/`sign`.
- 010 LDI: reg[`[9:8]`] ← `[3:0]`.
- 011 JMP: PC ← `[AW-1:0]`.
- 100 JZ: jump if Z=1; otherwise PC+1.
- 101 JC: jump if C=1; otherwise PC+1.
- 110 JS: jump if S=1; otherwise PC+1.
- 111 HALT.
- Only ALU updates the flags. LDI, OUT and jumps leave Z/C/S unchanged.
- Non-jump instructions and untaken jumps set PC ← PC+1 mod 2^AW. 2^AW−1 wraps to 0.
- A write to reg[rd] where rd equals ra or rb reads the old value; the write lands at the end of EXEC.
- FSM states: IDLE, FETCH, DECODE, EXEC, HALTED.
  - IDLE: `start`=1 → FETCH; otherwise stay.
  - FETCH → DECODE: `iaddr`=PC is held.
  - DECODE → EXEC: IR ← `idata` at the end of DECODE.
  - EXEC → FETCH: the instruction commits at the end of EXEC.
  - EXEC with HALT → HALTED: PC is not incremented.
  - HALTED: `start`=1 clears PC to 0 and goes to FETCH. Registers and flags are retained; `start` is ignored in every other state.
- Outside EXEC, `A`, `B`, `ALUop` and `L` are driven to 0. In EXEC they are decoded from IR for every opcode; only ALU writes back.
- Reset values: state IDLE, PC 0, `iaddr` 0, regs 0, Z/C/S 0, IR 0, `out` 0, `out_valid` 0, `halted` 0.
- Reset asserted mid-instruction aborts it; no partial register or flag write occurs.

## Timing
- Every instruction takes exactly 3 cycles (FETCH, DECODE, EXEC), with no branch penalty.
- The ALU path is combinational within EXEC: operands are stable from IR, and `R` plus the flags are sampled at the EXEC clock edge.
- A flag written by instruction N is visible to a conditional jump at N+1.
- `out_valid` rises in the cycle after OUT's EXEC and lasts exactly 1 cycle.
- `halted` rises in the cycle after HALT's EXEC.
- From `start` sampled high in IDLE: first `iaddr`=0 is in FETCH in the next cycle.

## Structure
- Package `alu_seq_pkg`: opcode constants (OP_OUT … OP_HALT), the FSM state enum, and instruction field position constants.
- Sub-module `rf4x4`: 4 entries × 4 bits, two combinational read ports, one synchronous write port, asynchronous active-low reset to 0.
- ALU is external; the bench connects the real ALU to `A`/`B`/`ALUop`/`L`/`R`/flags.

## Test plan
- Reset mid-EXEC of an ALU instruction → all outputs at their reset values; regs and flags still 0 after release.
- LDI r0,5; LDI r1,3; ALU add r2=r0+r1; OUT r2 → `out`=8, `out_valid` single pulse, Z=0, program halts after HALT with `halted`=1.
- LDI r0,15; LDI r1,1; ALU add; JC 0x20 → PC becomes 0x20; with r1=0 instead, execution falls through to PC+1.
- ALU result 0 followed by JZ, then LDI, then JZ → both jumps taken, because LDI preserves Z.
- JMP 0xFF; at 0xFF a non-jump instruction → next `iaddr`=0x00 (wrap).
- HALT then `start` pulse → `halted` drops, `iaddr`=0 in the next FETCH, register values retained and visible via OUT.
